// File: rtl/cpu_bus_sched.sv
// Z80 clock-enable generator and single-port RAM time-slicer (CPU / video / host download).
// Define SCHED_STALL_CNT_EN to add the saturating stall_cnt output (frozen T-states).

module cpu_bus_sched #(
  parameter int DIV = 8,
  parameter int AW  = 16
) (
  input  logic          clock,
  input  logic          reset,
  output logic          cpu_cep,
  output logic          cpu_cen,
  input  logic          cpu_mreq,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic          cpu_rfsh,
  input  logic [AW-1:0] cpu_a,
  input  logic [7:0]    cpu_q,
  output logic [7:0]    cpu_d,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_a,
  output logic          vid_ack,
  output logic [7:0]    vid_d,
  input  logic          dl_req,
  input  logic [AW-1:0] dl_a,
  input  logic [7:0]    dl_q,
  output logic          dl_ack,
  output logic [AW-1:0] ram_a,
  output logic [7:0]    ram_d,
  output logic          ram_we,
  input  logic [7:0]    ram_q,
  output logic          frozen
`ifdef SCHED_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] P_ZERO = '0;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] P_CEN  = PW'(DIV / 2);
  localparam logic [PW-1:0] P_C    = PW'(1);
  localparam logic [PW-1:0] P_V    = PW'(DIV / 2 + 1);

  typedef enum logic [1:0] {RUN, DRAIN, FREEZE} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   p_reg;
  logic            wr_done_reg;
  logic            rd_pend_reg;
  logic [7:0]      cpu_d_reg;
  logic            vid_ack_reg;
  logic [7:0]      vid_d_reg;
  logic [AW-1:0]   ram_a_reg;
  logic [7:0]      ram_d_reg;

  logic            c_slot, cpu_rd_hit, cpu_wr_hit, dl_hit, vid_hit;

  // State changes that affect the enables only land on a T-state boundary.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (dl_req) state_next = DRAIN;
      DRAIN:   if (!dl_req) state_next = RUN;
               else if (p_reg == P_LAST) state_next = FREEZE;
      FREEZE:  if (!dl_req && p_reg == P_LAST) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    c_slot     = !reset && p_reg == P_C && state_reg != FREEZE && !cpu_mreq && cpu_rfsh;
    cpu_rd_hit = c_slot && !cpu_rd;
    cpu_wr_hit = c_slot && !cpu_wr && !wr_done_reg;
    dl_hit     = !reset && p_reg == P_C && state_reg == FREEZE && dl_req;
    vid_hit    = !reset && p_reg == P_V && vid_req;
  end

  // Slot outputs are driven in the slot cycle itself; otherwise the bus holds.
  always_comb begin
    ram_a  = ram_a_reg;
    ram_d  = ram_d_reg;
    ram_we = 1'b0;
    dl_ack = 1'b0;
    if (vid_hit) ram_a = vid_a;
    if (cpu_rd_hit || cpu_wr_hit) ram_a = cpu_a;
    if (cpu_wr_hit) begin
      ram_d  = cpu_q;
      ram_we = 1'b1;
    end
    if (dl_hit) begin
      ram_a  = dl_a;
      ram_d  = dl_q;
      ram_we = 1'b1;
      dl_ack = 1'b1;
    end
  end

  assign cpu_cep = !reset && p_reg == P_ZERO && state_reg != FREEZE;
  assign cpu_cen = !reset && p_reg == P_CEN && state_reg != FREEZE;
  assign frozen  = (state_reg == FREEZE);
  assign cpu_d   = cpu_d_reg;
  assign vid_ack = vid_ack_reg;
  // RAM data is only valid during the ack cycle, so pass it straight through then.
  assign vid_d   = vid_ack_reg ? ram_q : vid_d_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      p_reg       <= '0;
      state_reg   <= RUN;
      wr_done_reg <= 1'b0;
      rd_pend_reg <= 1'b0;
      cpu_d_reg   <= 8'hFF;
      vid_ack_reg <= 1'b0;
      vid_d_reg   <= 8'h00;
      ram_a_reg   <= '0;
      ram_d_reg   <= 8'h00;
    end else begin
      p_reg       <= (p_reg == P_LAST) ? P_ZERO : p_reg + PW'(1);
      state_reg   <= state_next;
      ram_a_reg   <= ram_a;
      ram_d_reg   <= ram_d;
      rd_pend_reg <= cpu_rd_hit;
      vid_ack_reg <= vid_hit;
      if (cpu_wr_hit)
        wr_done_reg <= 1'b1;
      else if (cpu_mreq)
        wr_done_reg <= 1'b0;
      if (rd_pend_reg)
        cpu_d_reg <= ram_q;
      if (vid_ack_reg)
        vid_d_reg <= ram_q;
    end
  end

`ifdef SCHED_STALL_CNT_EN
  always_ff @(posedge clock) begin
    if (reset)
      stall_cnt <= 16'h0000;
    else if (state_reg == FREEZE && p_reg == P_ZERO && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'h0001;
  end
`endif

endmodule

// File: doc/cpu_bus_sched.md
Name: cpu_bus_sched

Overview:
- Generates the Z80 CPU clock enables (cep/cen) from the master clock.
- Time-slices one synchronous single-port system RAM between three users: CPU memory cycles, the video fetcher and the host download port.
- Video gets a fixed slot in every CPU T-state. Host downloads freeze the CPU on a T-state boundary and then write into the CPU slot.
- Sits between the CPU wrapper, the video generator and the RAM macro.

Parameters:
- DIV, 8: master clocks per CPU T-state. Must be even and >=6.
- AW, 16: RAM address width.

Ports:
- clock  in  1  master clock
- reset  in  1  synchronous, active-high
- cpu_cep  out  1  CPU positive-phase clock enable
- cpu_cen  out  1  CPU negative-phase clock enable
- cpu_mreq  in  1  CPU MREQ_n, active-low
- cpu_rd  in  1  CPU RD_n, active-low
- cpu_wr  in  1  CPU WR_n, active-low
- cpu_rfsh  in  1  CPU RFSH_n, active-low
- cpu_a  in  AW  CPU address
- cpu_q  in  8  CPU write data
- cpu_d  out  8  CPU read data, held until the next CPU read
- vid_req  in  1  video fetch request, level
- vid_a  in  AW  video fetch address
- vid_ack  out  1  one-cycle pulse; vid_d valid in that cycle
- vid_d  out  8  video read data
- dl_req  in  1  host download pending, level
- dl_a  in  AW  download address
- dl_q  in  8  download data
- dl_ack  out  1  one-cycle pulse; write accepted, host advances
- ram_a  out  AW  RAM address
- ram_d  out  8  RAM write data
- ram_we  out  1  RAM write strobe, one cycle
- ram_q  in  8  RAM read data, valid one clock after ram_a
- frozen  out  1  high while the CPU is frozen

Behaviour:
- Phase counter p runs 0..DIV-1 and wraps. It runs in every state and is cleared only by reset.
- Slots: C = phase 1 (CPU, or download when frozen). V = phase DIV/2+1 (video).
- Enables:
  - cpu_cep = (p==0) && state!=FREEZE
  - cpu_cen = (p==DIV/2) && state!=FREEZE
  - Both are combinational from registered state.
- States:
  - RUN -> DRAIN when dl_req=1.
  - DRAIN -> FREEZE at the next p==0 if dl_req is still 1, else DRAIN -> RUN. The current T-state always completes.
  - FREEZE -> RUN at p==0 when dl_req=0.
- frozen = (state==FREEZE).
- CPU slot, RUN/DRAIN only:
  - Access only when cpu_mreq=0 and cpu_rfsh=1; refresh cycles never touch RAM.
  - Read (cpu_rd=0): ram_a=cpu_a at p=1. cpu_d captures ram_q at the end of p=2 and is valid from p=3.
  - Write (cpu_wr=0) with wr_done=0: ram_a=cpu_a, ram_d=cpu_q, ram_we=1 at p=1, then wr_done=1.
  - wr_done clears when cpu_mreq=1. Exactly one write per CPU write cycle, however many T-states it spans.
- Video slot: if vid_req=1 at p=V, ram_a=vid_a. vid_d captures ram_q and vid_ack=1 at p=V+1. At most one ack per T-state.
- Download slot, FREEZE only: if dl_req=1 at p=1, ram_a=dl_a, ram_d=dl_q, ram_we=1, dl_ack=1 in the same cycle.
- Outside active slots: ram_we=0; ram_a holds its last value.
- Slots C and V never overlap, so simultaneous CPU/video requests need no arbitration.
- The CPU is stopped only between T-states. CPU bus signals are frozen with it, so an in-flight cycle resumes correctly after unfreeze.
- A dl_req drop during DRAIN returns to RUN with no lost CPU enables.
- Reset values:
  - state=RUN, p=0, wr_done=0, cpu_d=8'hFF, vid_d=0
  - vid_ack=0, dl_ack=0, ram_we=0, ram_a=0, ram_d=0
- Reset mid-FREEZE/DRAIN: immediate RUN; no further dl_ack or ram_we.

Optional Feature:
- SCHED_STALL_CNT_EN:
  - Adds output stall_cnt [15:0], reset to 0.
  - Increments once per frozen T-state (at p==0 while in FREEZE) and saturates at 16'hFFFF.
- Without the macro: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: reset high for 3 clocks -> cpu_cep/cen=0, ram_we=0, cpu_d=FF. After release, cpu_cep high in the 1st cycle, then every 8; cpu_cen 4 cycles after each cpu_cep.
- CPU read: RAM[0x1234]=0x5A, mreq=rd=0, a=0x1234 -> ram_a=0x1234 at p=1; cpu_d=0x5A from p=3.
- CPU write held 3 T-states: a=0x4000, q=0xA5 -> exactly one ram_we pulse; RAM[0x4000]=0xA5. With rfsh=0 and mreq=0 -> no ram_we.
- Video + CPU read every T-state: vid_a=0x2000 -> ram_a=0x2000 at p=5; vid_ack at p=6 with RAM data; CPU data is unaffected.
- Download: dl_req raised at p=3 -> cep/cen stop from the next p=0. Four bytes 0x11..0x44 to 0x8000..0x8003 -> four dl_ack pulses, each at p=1 of successive frozen T-states. dl_req dropped -> cpu_cep resumes at the following p=0. With SCHED_STALL_CNT_EN, stall_cnt=4.
- Reset while FREEZE -> frozen=0 and cpu_cep resume next cycle; no ram_we.
